// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline stall/flush sequencer for a 5-stage MIPS core. Turns
//            load-use hazard, taken-branch and data-memory-busy requests into
//            PC / IF/ID write enables, IF/ID flush, ID/EX bubble select and a
//            back-end freeze; tracks memory-wait timeout and keeps saturating
//            stall/flush statistics.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int LU_CYCLES   = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0]       S_RUN      = 2'd0;
  localparam logic [1:0]       S_LU_STALL = 2'd1;
  localparam logic [1:0]       S_MEM_WAIT = 2'd2;

  localparam logic [3:0]       C_LU_RELOAD = 4'(LU_CYCLES - 1);
  localparam logic             C_LU_MULTI  = (LU_CYCLES > 1);
  localparam logic [8:0]       C_TIMEOUT   = 9'(MEM_TIMEOUT);
  localparam logic [7:0]       C_WAIT_MAX  = 8'hFF;
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  logic [1:0]       r_state;
  logic [3:0]       r_lu_cnt;
  logic [7:0]       r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0]       w_state_nxt;
  logic [3:0]       w_lu_cnt_nxt;
  logic [7:0]       w_wait_cnt_nxt;
  logic             w_lu_pending;
  logic             w_timeout_hit;

  // A stall is still owed if we are in LU_STALL, or a freeze interrupted one
  // (the saved lu_cnt is what tells MEM_WAIT where to resume).
  assign w_lu_pending  = (r_state == S_LU_STALL) ||
                         ((r_state == S_MEM_WAIT) && (r_lu_cnt != 4'd0));
  assign w_timeout_hit = mem_busy_i && (({1'b0, r_wait_cnt} + 9'd1) == C_TIMEOUT);

  // State and bookkeeping registers; reset aborts any stall or wait at once.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= S_RUN;
      r_lu_cnt    <= 4'd0;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lu_cnt   <= w_lu_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
      if (!pc_write_o && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ifid_flush_o && (r_flush_cnt != C_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Next-state: memory freeze beats an owed load-use stall beats a new hazard.
  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    if (mem_busy_i) begin
      w_state_nxt    = S_MEM_WAIT;
      w_wait_cnt_nxt = (r_wait_cnt == C_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 8'd1;
    end else begin
      w_wait_cnt_nxt = 8'd0;
      if (w_lu_pending) begin
        w_lu_cnt_nxt = r_lu_cnt - 4'd1;
        w_state_nxt  = (r_lu_cnt == 4'd1) ? S_RUN : S_LU_STALL;
      end else if (hazard_i && C_LU_MULTI) begin
        w_lu_cnt_nxt = C_LU_RELOAD;
        w_state_nxt  = S_LU_STALL;
      end else begin
        w_state_nxt  = S_RUN;
      end
    end
  end

  // Control outputs are decoded in the same cycle the request is seen.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (mem_busy_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_hold_o   = 1'b1;
    end else if (w_lu_pending || hazard_i) begin
      // A branch seen alongside a hazard is dropped; ID re-presents it later.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
    end
  end

  assign mem_timeout_o = r_timeout;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Self-checking bench for pipe_stall_ctrl. Two instances share the
//            stimulus: A (LU_CYCLES=3, MEM_TIMEOUT=4, CNT_W=4) and
//            B (LU_CYCLES=1, MEM_TIMEOUT=64, CNT_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  // Control word packing: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  localparam logic [4:0] C_NRM = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00010;
  localparam logic [4:0] C_FLS = 5'b11100;
  localparam logic [4:0] C_FRZ = 5'b00001;
  localparam logic [4:0] C_RST = 5'b00010;

  logic clk = 1'b0;
  logic rst_n, hazard, branch, busy;

  logic        pc_a, ifw_a, fl_a, bub_a, hold_a, to_a;
  logic [3:0]  scnt_a, fcnt_a;
  logic        pc_b, ifw_b, fl_b, bub_b, hold_b, to_b;
  logic [15:0] scnt_b, fcnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LU_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .hazard_i(hazard), .branch_taken_i(branch),
    .mem_busy_i(busy), .pc_write_o(pc_a), .ifid_write_o(ifw_a),
    .ifid_flush_o(fl_a), .idex_bubble_o(bub_a), .pipe_hold_o(hold_a),
    .mem_timeout_o(to_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
  );

  pipe_stall_ctrl #(.LU_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .hazard_i(hazard), .branch_taken_i(branch),
    .mem_busy_i(busy), .pc_write_o(pc_b), .ifid_write_o(ifw_b),
    .ifid_flush_o(fl_b), .idex_bubble_o(bub_b), .pipe_hold_o(hold_b),
    .mem_timeout_o(to_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
  );

  // Reference model: tracks owed stall cycles and the current busy run length
  // as plain integers; counters are integers clamped at their maximum.
  typedef struct {
    int stall_left;
    int busy_run;
    int to;
    int scnt;
    int fcnt;
    int ctrl;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int sat_inc(int v, int vmax);
    return (v >= vmax) ? vmax : v + 1;
  endfunction

  // Returns the post-edge model state; .ctrl holds this cycle's control word.
  function automatic mdl_t mdl_step(mdl_t m, int lu, int tmo, int cmax,
                                    bit rst, bit haz, bit br, bit bsy);
    mdl_t r = m;
    if (!rst) begin
      r = '{default: 0};
      r.ctrl = int'(C_RST);
      return r;
    end
    if (bsy) begin
      r.ctrl     = int'(C_FRZ);
      r.busy_run = m.busy_run + 1;
      if (r.busy_run >= tmo) r.to = 1;
      r.scnt     = sat_inc(m.scnt, cmax);
    end else begin
      r.busy_run = 0;
      if (m.stall_left > 0) begin
        r.ctrl       = int'(C_STL);
        r.stall_left = m.stall_left - 1;
        r.scnt       = sat_inc(m.scnt, cmax);
      end else if (haz) begin
        r.ctrl       = int'(C_STL);
        r.stall_left = lu - 1;
        r.scnt       = sat_inc(m.scnt, cmax);
      end else if (br) begin
        r.ctrl = int'(C_FLS);
        r.fcnt = sat_inc(m.fcnt, cmax);
      end else begin
        r.ctrl = int'(C_NRM);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Values of DUT A sampled in the most recent cycle, for table checks.
  int obs_ctrl_a, obs_s_a, obs_f_a, obs_to_a, obs_s_b, obs_to_b, obs_ctrl_b;

  task automatic cycle(input bit r, input bit h, input bit b, input bit m);
    mdl_t na, nb;
    @(negedge clk);
    rst_n = r; hazard = h; branch = b; busy = m;
    #1;
    na = mdl_step(ma, 3, 4, 15, r, h, b, m);
    nb = mdl_step(mb, 1, 64, 65535, r, h, b, m);
    obs_ctrl_a = int'({pc_a, ifw_a, fl_a, bub_a, hold_a});
    obs_ctrl_b = int'({pc_b, ifw_b, fl_b, bub_b, hold_b});
    obs_s_a = int'(scnt_a); obs_f_a = int'(fcnt_a); obs_to_a = int'(to_a);
    obs_s_b = int'(scnt_b); obs_to_b = int'(to_b);
    chk("A_ctrl", obs_ctrl_a, na.ctrl);
    chk("A_stall_cnt", obs_s_a, ma.scnt);
    chk("A_flush_cnt", obs_f_a, ma.fcnt);
    chk("A_timeout", obs_to_a, ma.to);
    chk("B_ctrl", obs_ctrl_b, nb.ctrl);
    chk("B_stall_cnt", obs_s_b, mb.scnt);
    chk("B_flush_cnt", int'(fcnt_b), mb.fcnt);
    chk("B_timeout", obs_to_b, mb.to);
    @(posedge clk);
    ma = na;
    mb = nb;
  endtask

  typedef struct {
    bit         rst, haz, br, bsy;
    logic [4:0] ctrl;
    int         scnt, fcnt, to;
  } vec_t;

  function automatic vec_t mk(bit r, bit h, bit b, bit m, logic [4:0] c,
                              int s, int f, int t);
    vec_t v;
    v.rst = r; v.haz = h; v.br = b; v.bsy = m;
    v.ctrl = c; v.scnt = s; v.fcnt = f; v.to = t;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int burst;
    // Hand-derived expectations for instance A (LU=3, TIMEOUT=4, CNT_W=4).
    // Counter/flag columns are the registered values seen during that cycle.
    tbl.push_back(mk(0,0,0,0, C_RST,  0, 0, 0));
    tbl.push_back(mk(1,0,0,0, C_NRM,  0, 0, 0));
    tbl.push_back(mk(1,0,0,0, C_NRM,  0, 0, 0));
    tbl.push_back(mk(1,0,0,0, C_NRM,  0, 0, 0));
    tbl.push_back(mk(1,1,0,0, C_STL,  0, 0, 0));  // hazard: 3 bubble cycles
    tbl.push_back(mk(1,0,0,0, C_STL,  1, 0, 0));
    tbl.push_back(mk(1,0,0,0, C_STL,  2, 0, 0));
    tbl.push_back(mk(1,0,0,0, C_NRM,  3, 0, 0));
    tbl.push_back(mk(1,1,1,0, C_STL,  3, 0, 0));  // hazard beats branch
    tbl.push_back(mk(1,0,1,0, C_STL,  4, 0, 0));
    tbl.push_back(mk(1,0,1,0, C_STL,  5, 0, 0));
    tbl.push_back(mk(1,0,1,0, C_FLS,  6, 0, 0));  // branch re-presented
    tbl.push_back(mk(1,0,0,0, C_NRM,  6, 1, 0));
    tbl.push_back(mk(1,1,0,0, C_STL,  6, 1, 0));  // hazard, then freeze x4
    tbl.push_back(mk(1,0,0,1, C_FRZ,  7, 1, 0));
    tbl.push_back(mk(1,0,0,1, C_FRZ,  8, 1, 0));
    tbl.push_back(mk(1,0,0,1, C_FRZ,  9, 1, 0));
    tbl.push_back(mk(1,0,0,1, C_FRZ, 10, 1, 0));  // 4th busy edge sets timeout
    tbl.push_back(mk(1,0,0,0, C_STL, 11, 1, 1));  // 2 remaining bubbles
    tbl.push_back(mk(1,0,0,0, C_STL, 12, 1, 1));
    tbl.push_back(mk(1,0,0,0, C_NRM, 13, 1, 1));
    tbl.push_back(mk(1,0,0,1, C_FRZ, 13, 1, 1));
    tbl.push_back(mk(1,1,0,0, C_STL, 14, 1, 1));  // hazard straight out of wait
    tbl.push_back(mk(1,0,0,0, C_STL, 15, 1, 1));  // saturated
    tbl.push_back(mk(1,0,0,0, C_STL, 15, 1, 1));
    tbl.push_back(mk(1,0,1,0, C_FLS, 15, 1, 1));
    tbl.push_back(mk(0,0,0,1, C_RST, 15, 2, 1));  // reset beats busy
    tbl.push_back(mk(1,0,0,0, C_NRM,  0, 0, 0));

    rst_n = 1'b0; hazard = 1'b0; branch = 1'b0; busy = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].haz, tbl[i].br, tbl[i].bsy);
      chk("tbl_ctrl", obs_ctrl_a, int'(tbl[i].ctrl));
      chk("tbl_stall_cnt", obs_s_a, tbl[i].scnt);
      chk("tbl_flush_cnt", obs_f_a, tbl[i].fcnt);
      chk("tbl_timeout", obs_to_a, tbl[i].to);
    end

    // Reset in the middle of a load-use stall abandons the remaining bubbles.
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("rst_mid_stall_ctrl", obs_ctrl_a, int'(C_RST));
    cycle(1, 0, 0, 0);
    chk("after_rst_stall_ctrl", obs_ctrl_a, int'(C_NRM));
    chk("after_rst_stall_cnt", obs_s_a, 0);

    // Reset in the middle of a memory wait.
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    chk("after_rst_wait_ctrl", obs_ctrl_a, int'(C_NRM));

    // Long freeze: B times out on exactly its 64th busy edge.
    for (int i = 0; i < 70; i++) begin
      cycle(1, 0, 0, 1);
      if (i == 63) chk("B_timeout_before", obs_to_b, 0);
      if (i == 64) chk("B_timeout_at", obs_to_b, 1);
    end
    cycle(1, 0, 1, 0);
    chk("B_timeout_sticky", obs_to_b, 1);
    chk("B_freeze_count", obs_s_b, 70);
    chk("A_stall_sat", obs_s_a, 15);

    // Randomized traffic against the model (checked inside cycle()).
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      bit r, h, b, m;
      r = ($urandom_range(0, 59) != 0);
      if (burst > 0) begin
        m = 1'b1;
        burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        m = 1'b1;
        burst = $urandom_range(0, 6);
      end else begin
        m = 1'b0;
      end
      h = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      cycle(r, h, b, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Consumer end of the load-use hazard request. It takes hazard, branch-taken and data-memory-busy requests and sequences the pipeline write enables, flushes and bubble select for the 5-stage MIPS core. It sits between the hazard detection logic in ID and the PC, IF/ID and ID/EX registers. It handles multi-cycle load-use stalls, memory wait freezes with timeout, and keeps stall and flush statistics counters.

Parameters:
LU_CYCLES, 1, number of stall cycles inserted per load-use hazard (1..15)
MEM_TIMEOUT, 64, consecutive mem_busy_i cycles after which mem_timeout_o sets (1..255)
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-low
hazard_i  in  1  load-use hazard detected for the instruction currently in ID
branch_taken_i  in  1  branch/jump in ID resolved taken
mem_busy_i  in  1  data memory has not completed the MEM-stage access
pc_write_o  out  1  PC register write enable
ifid_write_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  IF/ID register loads NOP
idex_bubble_o  out  1  select zero control word into ID/EX (bubble mux select)
pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB registers
mem_timeout_o  out  1  sticky memory-wait timeout flag
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1, saturating

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Internal registers: lu_cnt (4 bits), wait_cnt (8 bits).
- Control outputs are combinational from the current state and inputs, and are valid in the same cycle. Statistics and flags are registered.
- While rst_i=0: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, pipe_hold_o=0. At the next edge: state=RUN, lu_cnt=0, wait_cnt=0, mem_timeout_o=0, both counters=0. A reset asserted mid-stall or mid-wait aborts it immediately.
- Priority in every state: mem_busy_i > load-use stall > branch flush.
- Freeze (mem_busy_i=1, any state):
  - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0, ifid_flush_o=0.
  - Next state is MEM_WAIT. wait_cnt increments, saturating at 255.
  - When wait_cnt+1 reaches MEM_TIMEOUT, mem_timeout_o sets and stays set until reset.
  - lu_cnt is held, and the interrupted state is remembered: return to LU_STALL if lu_cnt!=0, else RUN.
- MEM_WAIT with mem_busy_i=0: clear wait_cnt. Apply RUN or LU_STALL rules this cycle according to the saved lu_cnt, with no dead cycle.
- RUN with hazard_i=1:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, pipe_hold_o=0.
  - branch_taken_i is ignored this cycle; the branch is re-presented after the stall.
  - If LU_CYCLES>1: lu_cnt=LU_CYCLES-1, next state LU_STALL. Else stay in RUN.
- LU_STALL (not frozen):
  - Same outputs as a RUN load-use stall. hazard_i and branch_taken_i are ignored.
  - lu_cnt decrements. When lu_cnt==1 at the edge, next state is RUN.
- RUN with hazard_i=0 and branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0.
- RUN with no requests: pc_write_o=1, ifid_write_o=1, all other control outputs 0.
- Counters increment on the edge ending a qualifying cycle and saturate at 2^CNT_W-1. No wrap-around. Reset cycles are not counted.
- Total load-use stall cycles per hazard = LU_CYCLES, plus any freeze cycles that intervene.

Test Plan:
1. Reset, then 3 idle cycles -> pc_write_o=1, ifid_write_o=1, bubble/flush/hold=0, stall_cnt_o=0, flush_cnt_o=0.
2. LU_CYCLES=2, hazard_i=1 for 1 cycle -> 2 consecutive cycles of pc_write_o=0 and idex_bubble_o=1, then RUN; stall_cnt_o=2.
3. hazard_i=1 and branch_taken_i=1 in the same cycle -> bubble only, ifid_flush_o=0, flush_cnt_o unchanged. Next cycle branch_taken_i=1 -> ifid_flush_o=1, flush_cnt_o=1.
4. LU_CYCLES=3, mem_busy_i=1 for 4 cycles starting in the 2nd stall cycle -> 4 hold cycles, then the 2 remaining bubble cycles; stall_cnt_o=7.
5. MEM_TIMEOUT=4, mem_busy_i=1 for 6 cycles -> mem_timeout_o rises after the 4th busy edge and stays 1 after busy drops, until rst_i=0.
6. CNT_W=4, 20 stall cycles -> stall_cnt_o saturates at 15. rst_i=0 during a LU_STALL -> next cycle state RUN and counters 0.
